// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential advance, jump/branch/trap
// redirects, hazard stalls, halt and the instruction-memory fetch handshake.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        trap_i,
    input  logic        halt_i,
    input  logic        fetch_ack_i,
    output logic [31:0] pc_o,
    output logic        fetch_req_o,
    output logic        pc_valid_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic [31:0] epc_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] epc_r;
    logic [31:0] epc_next_s;
    logic        fetch_req_s;
    logic        pc_valid_s;
    logic        flush_if_s;
    logic        flush_id_s;
    logic        redirect_ok_s;

    // State, PC and EPC registers; reset aborts any pending fetch or redirect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= BOOT;
            pc_r    <= RESET_PC;
            epc_r   <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            epc_r   <= epc_next_s;
        end
    end

    // Branch and jump only act while the fetch path is live (not BOOT/HALTED).
    always_comb begin
        redirect_ok_s = (state_r == FETCH) || (state_r == HOLD);
    end

    // Next-state, next-PC and handshake/flush outputs, in redirect priority order.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        epc_next_s   = epc_r;
        fetch_req_s  = 1'b0;
        pc_valid_s   = 1'b0;
        flush_if_s   = 1'b0;
        flush_id_s   = 1'b0;

        if (state_r == BOOT) begin
            next_state_s = FETCH;
        end else if (trap_i) begin
            pc_next_s    = TRAP_VEC;
            epc_next_s   = pc_r;
            flush_if_s   = 1'b1;
            flush_id_s   = 1'b1;
            next_state_s = FETCH;
        end else if (br_taken_i && redirect_ok_s) begin
            pc_next_s    = br_target_i;
            flush_if_s   = 1'b1;
            flush_id_s   = 1'b1;
            next_state_s = FETCH;
        end else if (jmp_i && redirect_ok_s) begin
            // The jump itself sits in ID and must survive, so only IF is squashed.
            pc_next_s    = jmp_target_i;
            flush_if_s   = 1'b1;
            next_state_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    if (stall_i) begin
                        next_state_s = HOLD;
                    end else begin
                        fetch_req_s = 1'b1;
                        if (fetch_ack_i) begin
                            pc_valid_s = 1'b1;
                            pc_next_s  = pc_r + 32'd1;
                        end else begin
                            pc_next_s  = pc_r;
                        end
                        if (halt_i) begin
                            next_state_s = HALTED;
                        end else begin
                            next_state_s = FETCH;
                        end
                    end
                end
                HOLD: begin
                    // Leave HOLD with the PC unchanged so the held word is re-fetched.
                    if (stall_i) begin
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                HALTED: begin
                    next_state_s = HALTED;
                end
                default: begin
                    next_state_s = FETCH;
                end
            endcase
        end
    end

    assign pc_o        = pc_r;
    assign epc_o       = epc_r;
    assign state_o     = state_r;
    assign fetch_req_o = fetch_req_s;
    assign pc_valid_o  = pc_valid_s;
    assign flush_if_o  = flush_if_s;
    assign flush_id_o  = flush_id_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_pc_sequencer;

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap;
    logic        halt;
    logic        fetch_ack;
    logic [31:0] pc;
    logic        fetch_req;
    logic        pc_valid;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] epc;
    logic [1:0]  state;

    pc_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .trap_i       (trap),
        .halt_i       (halt),
        .fetch_ack_i  (fetch_ack),
        .pc_o         (pc),
        .fetch_req_o  (fetch_req),
        .pc_valid_o   (pc_valid),
        .flush_if_o   (flush_if),
        .flush_id_o   (flush_id),
        .epc_o        (epc),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  st;
        logic [3:0]  fl;   // {fetch_req, pc_valid, flush_if, flush_id}
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // ctl = {rst, stall, jmp, br, trap, halt, ack}
    task automatic v(input logic [6:0] ctl, input logic [31:0] jt, input logic [31:0] bt,
                     input logic [31:0] exp_pc, input logic [31:0] exp_epc,
                     input logic [1:0] exp_st, input logic [3:0] exp_fl);
        exp_t x;
        @(posedge clk);
        #1;
        {rst, stall, jmp, br_taken, trap, halt, fetch_ack} = ctl;
        jmp_target = jt;
        br_target  = bt;
        step_no++;
        x.idx = step_no;
        x.pc  = exp_pc;
        x.epc = exp_epc;
        x.st  = exp_st;
        x.fl  = exp_fl;
        q.push_back(x);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("pc_o",      e.idx, pc,                 e.pc);
            chk("epc_o",     e.idx, epc,                e.epc);
            chk("state_o",   e.idx, {30'd0, state},     {30'd0, e.st});
            chk("fetch_req", e.idx, {31'd0, fetch_req}, {31'd0, e.fl[3]});
            chk("pc_valid",  e.idx, {31'd0, pc_valid},  {31'd0, e.fl[2]});
            chk("flush_if",  e.idx, {31'd0, flush_if},  {31'd0, e.fl[1]});
            chk("flush_id",  e.idx, {31'd0, flush_id},  {31'd0, e.fl[0]});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        {rst, stall, jmp, br_taken, trap, halt, fetch_ack} = 7'b1000001;
        jmp_target = 32'h0;
        br_target  = 32'h0;

        // Reset held three cycles, then BOOT, then sequential with ack tied high
        v(7'b1000001, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b1000001, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b1000001, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b0000001, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b0000001, 32'h0, 32'h0, 32'h0, 32'h0, S_FETCH, 4'b1100);
        v(7'b0000001, 32'h0, 32'h0, 32'h1, 32'h0, S_FETCH, 4'b1100);
        v(7'b0000001, 32'h0, 32'h0, 32'h2, 32'h0, S_FETCH, 4'b1100);
        v(7'b0000001, 32'h0, 32'h0, 32'h3, 32'h0, S_FETCH, 4'b1100);
        v(7'b0000001, 32'h0, 32'h0, 32'h4, 32'h0, S_FETCH, 4'b1100);
        // Wait states at pc 5
        v(7'b0000000, 32'h0, 32'h0, 32'h5, 32'h0, S_FETCH, 4'b1000);
        v(7'b0000000, 32'h0, 32'h0, 32'h5, 32'h0, S_FETCH, 4'b1000);
        // Stall three cycles with ack high: ack ignored
        v(7'b0100001, 32'h0, 32'h0, 32'h5, 32'h0, S_FETCH, 4'b0000);
        v(7'b0100001, 32'h0, 32'h0, 32'h5, 32'h0, S_HOLD,  4'b0000);
        v(7'b0100001, 32'h0, 32'h0, 32'h5, 32'h0, S_HOLD,  4'b0000);
        // Release: PC still held, then 5 acked once, then 6
        v(7'b0000001, 32'h0, 32'h0, 32'h5, 32'h0, S_HOLD,  4'b0000);
        v(7'b0000001, 32'h0, 32'h0, 32'h5, 32'h0, S_FETCH, 4'b1100);
        v(7'b0000001, 32'h0, 32'h0, 32'h6, 32'h0, S_FETCH, 4'b1100);
        // Jump to 0x20 (ack in redirect cycle discarded)
        v(7'b0010001, 32'h20, 32'h0, 32'h7, 32'h0, S_FETCH, 4'b0010);
        // Branch + jump: branch wins
        v(7'b0011001, 32'h40, 32'h80, 32'h20, 32'h0, S_FETCH, 4'b0011);
        // Jump alone: flush_id stays 0
        v(7'b0010001, 32'h40, 32'h0, 32'h80, 32'h0, S_FETCH, 4'b0010);
        v(7'b0000000, 32'h0, 32'h0, 32'h40, 32'h0, S_FETCH, 4'b1000);
        // Trap at 0x33 with stall
        v(7'b0010000, 32'h33, 32'h0, 32'h40, 32'h0, S_FETCH, 4'b0010);
        v(7'b0100101, 32'h0, 32'h0, 32'h33, 32'h0, S_FETCH, 4'b0011);
        v(7'b0000000, 32'h0, 32'h0, 32'h100, 32'h33, S_FETCH, 4'b1000);
        // Halt with ack at 0x4F: word valid, PC advances to 0x50, HALTED
        v(7'b0010000, 32'h4F, 32'h0, 32'h100, 32'h33, S_FETCH, 4'b0010);
        v(7'b0000011, 32'h0, 32'h0, 32'h4F, 32'h33, S_FETCH, 4'b1100);
        // Branch and jump ignored in HALTED
        v(7'b0011001, 32'h40, 32'h80, 32'h50, 32'h33, S_HALTED, 4'b0000);
        // Trap leaves HALTED
        v(7'b0000100, 32'h0, 32'h0, 32'h50, 32'h33, S_HALTED, 4'b0011);
        v(7'b0000000, 32'h0, 32'h0, 32'h100, 32'h50, S_FETCH, 4'b1000);
        // Branch + halt: redirect wins, no HALTED entry
        v(7'b0001011, 32'h0, 32'h10, 32'h100, 32'h50, S_FETCH, 4'b0011);
        v(7'b0000000, 32'h0, 32'h0, 32'h10, 32'h50, S_FETCH, 4'b1000);
        // Wrap from 0xFFFF_FFFF
        v(7'b0010000, 32'hFFFF_FFFF, 32'h0, 32'h10, 32'h50, S_FETCH, 4'b0010);
        v(7'b0000001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h50, S_FETCH, 4'b1100);
        v(7'b0000000, 32'h0, 32'h0, 32'h0, 32'h50, S_FETCH, 4'b1000);
        // Async reset during HOLD at 0x77, checked before the next edge
        v(7'b0010000, 32'h77, 32'h0, 32'h0, 32'h50, S_FETCH, 4'b0010);
        v(7'b0100000, 32'h0, 32'h0, 32'h77, 32'h50, S_FETCH, 4'b0000);
        v(7'b0100000, 32'h0, 32'h0, 32'h77, 32'h50, S_HOLD,  4'b0000);
        v(7'b1100000, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b1000000, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b0000000, 32'h0, 32'h0, 32'h0, 32'h0, S_BOOT,  4'b0000);
        v(7'b0000000, 32'h0, 32'h0, 32'h0, 32'h0, S_FETCH, 4'b1000);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
